unit_arbiter: RTL and testbench

- Shares one execution-unit port (ALU/MEM selected by unit_sel) among NUM_THREADS thread FSMs.
- Each thread presents a request with its unit_sel/ctrl/operands. The arbiter grants one requester per cycle, round-robin.
- The winner's request is routed to the unit, and unit_out is returned in the same cycle.
- A lock input lets a thread hold the unit over consecutive cycles, e.g. a multi-cycle MEM fetch.

---
 rtl/unit_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_unit_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/unit_arbiter.sv
// unit_arbiter: shares one execution-unit port (ALU/MEM) among NUM_THREADS
// thread FSMs. Round-robin grant, same-cycle routing, and an optional grant
// lock so a thread can hold the unit across consecutive cycles.
// Optional build macro: UNIT_ARB_LOCK_TIMEOUT_EN bounds a lock to LOCK_MAX
// consecutive grants; without it locks are unbounded.

package unit_arbiter_pkg;
    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2
    } unit_sel_t;

    localparam int SEL_W = $bits(unit_sel_t);
endpackage

// Per-thread routing slice: forces the thread's request fields to zero
// unless it holds the grant, so the OR-combine downstream never sees
// values (or X) from a non-granted thread.
module unit_arbiter_lane
    import unit_arbiter_pkg::*;
(
    input  logic             gnt,
    input  unit_sel_t        sel,
    input  logic [31:0]      ctrl,
    input  logic [31:0]      in0,
    input  logic [31:0]      in1,
    output logic [SEL_W-1:0] sel_m,
    output logic [31:0]      ctrl_m,
    output logic [31:0]      in0_m,
    output logic [31:0]      in1_m
);
    assign sel_m  = {SEL_W{gnt}} & sel;
    assign ctrl_m = {32{gnt}} & ctrl;
    assign in0_m  = {32{gnt}} & in0;
    assign in1_m  = {32{gnt}} & in1;
endmodule

module unit_arbiter
    import unit_arbiter_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int IDX_W       = $clog2(NUM_THREADS),
    parameter int LOCK_MAX    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_THREADS-1:0]       thr_req,
    input  logic [NUM_THREADS-1:0]       thr_lock,
    input  unit_sel_t [NUM_THREADS-1:0]  thr_sel,
    input  logic [NUM_THREADS-1:0][31:0] thr_ctrl,
    input  logic [NUM_THREADS-1:0][31:0] thr_in0,
    input  logic [NUM_THREADS-1:0][31:0] thr_in1,
    output logic [NUM_THREADS-1:0]       thr_gnt,
    output logic [31:0]                  thr_out,
    output unit_sel_t                    unit_sel,
    output logic [31:0]                  unit_ctrl,
    output logic [1:0][31:0]             unit_in,
    input  logic [31:0]                  unit_out,
    output logic [IDX_W-1:0]             owner_idx
);

    if (NUM_THREADS < 2 || NUM_THREADS > 16 || LOCK_MAX < 1) begin : g_bad_param
        $error("unit_arbiter: parameter out of range");
    end

    logic [IDX_W-1:0]              last_idx;
    logic [IDX_W-1:0]              lock_idx;
    logic                          locked;
    logic                          lock_nxt;

    logic [NUM_THREADS-1:0]        req_eff;
    logic                          any_gnt;
    logic [IDX_W-1:0]              gnt_idx;
    logic [IDX_W-1:0]              scan_idx [NUM_THREADS];

    logic [NUM_THREADS-1:0][SEL_W-1:0] sel_m;
    logic [NUM_THREADS-1:0][31:0]      ctrl_m;
    logic [NUM_THREADS-1:0][31:0]      in0_m;
    logic [NUM_THREADS-1:0][31:0]      in1_m;
    logic [SEL_W-1:0]                  sel_or;

    // Requests are ignored while reset is asserted so nothing is granted
    // during reset even though selection is combinational.
    assign req_eff = rst ? '0 : thr_req;

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        // scan_idx[g] = (last_idx + 1 + g) mod NUM_THREADS, exact for any
        // thread count, not just powers of two.
        logic [IDX_W:0] sum;
        assign sum = {1'b0, last_idx} + (IDX_W+1)'(g + 1);
        assign scan_idx[g] = (sum >= (IDX_W+1)'(NUM_THREADS))
                           ? IDX_W'(sum - (IDX_W+1)'(NUM_THREADS))
                           : IDX_W'(sum);

        assign thr_gnt[g] = any_gnt && (gnt_idx == IDX_W'(g));

        unit_arbiter_lane u_lane (
            .gnt    (thr_gnt[g]),
            .sel    (thr_sel[g]),
            .ctrl   (thr_ctrl[g]),
            .in0    (thr_in0[g]),
            .in1    (thr_in1[g]),
            .sel_m  (sel_m[g]),
            .ctrl_m (ctrl_m[g]),
            .in0_m  (in0_m[g]),
            .in1_m  (in1_m[g])
        );
    end

    // Winner: lock owner if still requesting, else first requester after last_idx.
    always_comb begin
        any_gnt = 1'b0;
        gnt_idx = last_idx;
        if (locked && req_eff[lock_idx]) begin
            any_gnt = 1'b1;
            gnt_idx = lock_idx;
        end else begin
            for (int k = 0; k < NUM_THREADS; k++) begin
                if (!any_gnt && req_eff[scan_idx[k]]) begin
                    any_gnt = 1'b1;
                    gnt_idx = scan_idx[k];
                end
            end
        end
    end

    // OR-combine the masked lanes; at most one is non-zero, none gives idle values.
    always_comb begin
        sel_or    = '0;
        unit_ctrl = '0;
        unit_in   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            sel_or     = sel_or | sel_m[i];
            unit_ctrl  = unit_ctrl | ctrl_m[i];
            unit_in[0] = unit_in[0] | in0_m[i];
            unit_in[1] = unit_in[1] | in1_m[i];
        end
    end

    assign unit_sel  = unit_sel_t'(sel_or);
    assign thr_out   = unit_out;
    assign owner_idx = any_gnt ? gnt_idx : last_idx;

`ifdef UNIT_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lock_expire;

    // Count grants within a lock streak; the grant that opens a lock is 0,
    // and hitting LOCK_MAX-1 forces the release at this edge.
    always_comb begin
        cnt_nxt     = (locked && gnt_idx == lock_idx) ? lock_cnt + CNT_W'(1) : '0;
        lock_expire = (cnt_nxt == CNT_W'(LOCK_MAX - 1));
        lock_nxt    = any_gnt && thr_lock[gnt_idx] && !lock_expire;
    end

    // Streak counter clears whenever the lock is not carried forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_nxt ? cnt_nxt : '0;
        end
    end
`else
    assign lock_nxt = any_gnt && thr_lock[gnt_idx];
`endif

    // Round-robin pointer and lock state; a grant always moves the pointer
    // to the winner so a released owner does not get an extra turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_idx <= IDX_W'(NUM_THREADS - 1);
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            locked <= lock_nxt;
            if (any_gnt) begin
                last_idx <= gnt_idx;
                lock_idx <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_unit_arbiter.sv
// Directed bench for unit_arbiter: 4-thread main instance plus a 3-thread
// instance for non-power-of-2 wrap-around.
module tb_unit_arbiter;
    import unit_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           thr_req  = '0;
    logic [3:0]           thr_lock = '0;
    unit_sel_t [3:0]      thr_sel;
    logic [3:0][31:0]     thr_ctrl = '0;
    logic [3:0][31:0]     thr_in0  = '0;
    logic [3:0][31:0]     thr_in1  = '0;
    logic [3:0]           thr_gnt;
    logic [31:0]          thr_out;
    unit_sel_t            unit_sel;
    logic [31:0]          unit_ctrl;
    logic [1:0][31:0]     unit_in;
    logic [31:0]          unit_out;
    logic [1:0]           owner_idx;

    logic [2:0]           req3 = '0;
    logic [2:0]           lock3 = '0;
    unit_sel_t [2:0]      sel3;
    logic [2:0][31:0]     zero3 = '0;
    logic [2:0]           gnt3;
    logic [31:0]          out3;
    unit_sel_t            usel3;
    logic [31:0]          uctrl3;
    logic [1:0][31:0]     uin3;
    logic [1:0]           owner3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Simple shared unit: ALU add (ctrl 0) / sub, MEM returns a scrambled in0.
    assign unit_out = (unit_sel == UNIT_SEL_ALU) ?
                        ((unit_ctrl == 32'd0) ? unit_in[0] + unit_in[1] : unit_in[0] - unit_in[1]) :
                      (unit_sel == UNIT_SEL_MEM) ? (unit_in[0] ^ 32'hA5A5_A5A5) : 32'h0BAD_CAFE;

    unit_arbiter #(.NUM_THREADS(4), .LOCK_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .thr_req(thr_req), .thr_lock(thr_lock),
        .thr_sel(thr_sel), .thr_ctrl(thr_ctrl), .thr_in0(thr_in0), .thr_in1(thr_in1),
        .thr_gnt(thr_gnt), .thr_out(thr_out), .unit_sel(unit_sel), .unit_ctrl(unit_ctrl),
        .unit_in(unit_in), .unit_out(unit_out), .owner_idx(owner_idx)
    );

    unit_arbiter #(.NUM_THREADS(3), .LOCK_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst), .thr_req(req3), .thr_lock(lock3),
        .thr_sel(sel3), .thr_ctrl(zero3), .thr_in0(zero3), .thr_in1(zero3),
        .thr_gnt(gnt3), .thr_out(out3), .unit_sel(usel3), .unit_ctrl(uctrl3),
        .unit_in(uin3), .unit_out(32'd0), .owner_idx(owner3)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        thr_req  = '0;
        thr_lock = '0;
        req3     = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (thr_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", thr_gnt); end
        n_tests++; if (unit_sel !== UNIT_SEL_NONE) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", unit_sel); end
        n_tests++; if (unit_ctrl !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", unit_ctrl); end
        n_tests++; if (unit_in !== 64'd0) begin n_fail++; $display("FAIL reset_in got=%h exp=0", unit_in); end
        n_tests++; if (thr_out !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL reset_out got=%h exp=0badcafe", thr_out); end
        n_tests++; if (owner_idx !== 2'd3) begin n_fail++; $display("FAIL reset_owner got=%0d exp=3", owner_idx); end
        // requests during reset must not be granted
        thr_req = 4'b1111;
        #1;
        n_tests++; if (thr_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_req_gnt got=%b exp=0000", thr_gnt); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        thr_sel     = {UNIT_SEL_MEM, UNIT_SEL_ALU, UNIT_SEL_MEM, UNIT_SEL_MEM};
        thr_ctrl    = {32'h3333_3333, 32'd0, 32'h0000_0011, 32'h1234_5678};
        thr_in0     = {32'hFFFF_FFFF, 32'd5, 32'h0000_00FF, 32'hFFFF_0000};
        thr_in1     = {32'hFFFF_FFFF, 32'd7, 32'h0000_0001, 32'h0000_FFFF};
        thr_req     = 4'b0100;
        @(negedge clk);
        n_tests++; if (thr_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", thr_gnt); end
        n_tests++; if (unit_sel !== UNIT_SEL_ALU) begin n_fail++; $display("FAIL single_sel got=%0d exp=1", unit_sel); end
        n_tests++; if (unit_ctrl !== 32'd0) begin n_fail++; $display("FAIL single_ctrl got=%h exp=0", unit_ctrl); end
        n_tests++; if (unit_in[0] !== 32'd5 || unit_in[1] !== 32'd7) begin n_fail++; $display("FAIL single_in got=%0d,%0d exp=5,7", unit_in[0], unit_in[1]); end
        n_tests++; if (thr_out !== 32'd12) begin n_fail++; $display("FAIL single_out got=%0d exp=12", thr_out); end
        n_tests++; if (owner_idx !== 2'd2) begin n_fail++; $display("FAIL single_owner got=%0d exp=2", owner_idx); end
        next_cycle();
        thr_req = 4'b0000;
        @(negedge clk);
        n_tests++; if (unit_sel !== UNIT_SEL_NONE) begin n_fail++; $display("FAIL idle_sel got=%0d exp=0", unit_sel); end
        n_tests++; if (unit_ctrl !== 32'd0 || unit_in !== 64'd0) begin n_fail++; $display("FAIL idle_data got=%h/%h exp=0/0", unit_ctrl, unit_in); end
        n_tests++; if (owner_idx !== 2'd2 || thr_gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_owner got=%0d/%b exp=2/0000", owner_idx, thr_gnt); end
        next_cycle();
        thr_req = 4'b0010;
        @(negedge clk);
        n_tests++; if (unit_sel !== UNIT_SEL_MEM) begin n_fail++; $display("FAIL mem_sel got=%0d exp=2", unit_sel); end
        n_tests++; if (unit_ctrl !== 32'h11) begin n_fail++; $display("FAIL mem_ctrl got=%h exp=11", unit_ctrl); end
        n_tests++; if (thr_out !== 32'hA5A5_A55A) begin n_fail++; $display("FAIL mem_out got=%h exp=a5a5a55a", thr_out); end
        next_cycle();
        thr_req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] exp_o [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        thr_req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++; if (thr_gnt !== exp_g[c]) begin n_fail++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", c, thr_gnt, exp_g[c]); end
            n_tests++; if (owner_idx !== exp_o[c]) begin n_fail++; $display("FAIL fair_owner[%0d] got=%0d exp=%0d", c, owner_idx, exp_o[c]); end
            next_cycle();
        end
    endtask

    task automatic test_lock();
        logic [3:0] lk    [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] exp_g [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        thr_req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            thr_lock = lk[c];
            @(negedge clk);
            n_tests++; if (thr_gnt !== exp_g[c]) begin n_fail++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", c, thr_gnt, exp_g[c]); end
            next_cycle();
        end
        thr_lock = '0;
    endtask

    task automatic test_lock_req_drop();
        logic [3:0] rq    [4] = '{4'b1000, 4'b1011, 4'b0011, 4'b0011};
        logic [3:0] lk    [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] exp_g [4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            thr_req  = rq[c];
            thr_lock = lk[c];
            @(negedge clk);
            n_tests++; if (thr_gnt !== exp_g[c]) begin n_fail++; $display("FAIL drop_gnt[%0d] got=%b exp=%b", c, thr_gnt, exp_g[c]); end
            next_cycle();
        end
        thr_req  = '0;
        thr_lock = '0;
    endtask

    task automatic test_reset_midlock();
        logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100};
        do_reset();
        thr_req  = 4'b1111;
        thr_lock = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if (thr_gnt !== exp_g[c]) begin n_fail++; $display("FAIL midlock_gnt[%0d] got=%b exp=%b", c, thr_gnt, exp_g[c]); end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (thr_gnt !== 4'b0000) begin n_fail++; $display("FAIL midlock_rst_gnt got=%b exp=0000", thr_gnt); end
        n_tests++; if (owner_idx !== 2'd3) begin n_fail++; $display("FAIL midlock_rst_owner got=%0d exp=3", owner_idx); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (thr_gnt !== 4'b0001) begin n_fail++; $display("FAIL midlock_after_gnt got=%b exp=0001", thr_gnt); end
        next_cycle();
        thr_req  = '0;
        thr_lock = '0;
    endtask

    task automatic test_lock_timeout();
`ifdef UNIT_ARB_LOCK_TIMEOUT_EN
        logic [3:0] exp_g [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                   4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
`else
        logic [3:0] exp_g [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        do_reset();
        thr_req  = 4'b1111;
        thr_lock = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++; if (thr_gnt !== exp_g[c]) begin n_fail++; $display("FAIL timeout_gnt[%0d] got=%b exp=%b", c, thr_gnt, exp_g[c]); end
            next_cycle();
        end
        thr_req  = '0;
        thr_lock = '0;
    endtask

    task automatic test_wrap3();
        logic [2:0] rq    [9] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101};
        logic [2:0] exp_g [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req3 = rq[c];
            @(negedge clk);
            n_tests++; if (gnt3 !== exp_g[c]) begin n_fail++; $display("FAIL wrap3_gnt[%0d] got=%b exp=%b", c, gnt3, exp_g[c]); end
            next_cycle();
        end
        req3 = '0;
    endtask

    initial begin
        thr_sel = {UNIT_SEL_NONE, UNIT_SEL_NONE, UNIT_SEL_NONE, UNIT_SEL_NONE};
        sel3    = {UNIT_SEL_ALU, UNIT_SEL_ALU, UNIT_SEL_ALU};
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_lock_req_drop();
        test_reset_midlock();
        test_lock_timeout();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
